// File: rtl/conv_window_scheduler.sv
// conv_window_scheduler: tap/filter/window address and flag sequencer for the convolution datapath.
// Optional perf counters (perf_steps, perf_stalls) are enabled with `define CONV_SCHED_PERF_EN.
module conv_window_scheduler #(
    parameter int ADDR_W  = 4,
    parameter int NFILT_W = 2,
    parameter int FADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_cfg,
    input  logic [ADDR_W:0]    cfg_rowlen,
    input  logic [ADDR_W:0]    cfg_fsize,
    input  logic [ADDR_W-1:0]  cfg_stride,
    input  logic [NFILT_W-1:0] cfg_nfilt,
    input  logic               start,
    input  logic               step,
    output logic [ADDR_W-1:0]  data_addr,
    output logic [FADDR_W-1:0] filt_addr,
    output logic               co_filter,
    output logic               end_of_filter,
    output logic               end_of_row,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [15:0]        perf_steps,
    output logic [15:0]        perf_stalls
`endif
);
    localparam int CW = ADDR_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;

    logic [ADDR_W:0]    rowlen, fsize, k, p;
    logic [ADDR_W-1:0]  stride;
    logic [NFILT_W-1:0] nfilt, f;
    logic [FADDR_W-1:0] fb;
    logic [CW-1:0]      next_end;
    logic run, idle_done, last_tap, last_filt, last_win, cfg_bad, new_bad, go;

    assign run       = state == RUN;
    assign idle_done = state == IDLE || state == DONE;
    assign next_end  = CW'(p) + CW'(stride) + CW'(fsize);
    assign last_tap  = CW'(k) == CW'(fsize) - CW'(1);
    assign last_filt = f == nfilt - NFILT_W'(1);
    assign last_win  = next_end > CW'(rowlen);
    assign cfg_bad   = fsize == '0 || stride == '0 || nfilt == '0 || fsize > rowlen;
    assign new_bad   = cfg_fsize == '0 || cfg_stride == '0 || cfg_nfilt == '0 || cfg_fsize > cfg_rowlen;
    // A simultaneous ld_cfg wins over start so the pass never runs on a half-loaded config.
    assign go        = idle_done && start && !ld_cfg && !cfg_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            k       <= '0;
            f       <= '0;
            p       <= '0;
            fb      <= '0;
            rowlen  <= '0;
            fsize   <= '0;
            stride  <= '0;
            nfilt   <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (idle_done && ld_cfg) begin
                rowlen  <= cfg_rowlen;
                fsize   <= cfg_fsize;
                stride  <= cfg_stride;
                nfilt   <= cfg_nfilt;
                cfg_err <= new_bad;
            end
            if (go) begin
                state <= RUN;
                k     <= '0;
                f     <= '0;
                p     <= '0;
                fb    <= '0;
            end else if (run && step) begin
                if (!last_tap) begin
                    k <= k + 1'b1;
                end else begin
                    k <= '0;
                    if (!last_filt) begin
                        f  <= f + 1'b1;
                        fb <= fb + FADDR_W'(fsize);
                    end else begin
                        f  <= '0;
                        fb <= '0;
                        if (last_win) state <= DONE;
                        else p <= p + (ADDR_W+1)'(stride);
                    end
                end
            end
        end
    end

    assign data_addr     = run ? ADDR_W'(p + k) : '0;
    assign filt_addr     = run ? fb + FADDR_W'(k) : '0;
    assign co_filter     = run && last_tap;
    assign end_of_filter = run && last_filt;
    assign end_of_row    = run && last_win;
    assign busy          = run;
    assign done          = state == DONE;

`ifdef CONV_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || go) begin
            perf_steps  <= '0;
            perf_stalls <= '0;
        end else if (run) begin
            if (step && perf_steps != 16'hFFFF) perf_steps <= perf_steps + 1'b1;
            if (!step && perf_stalls != 16'hFFFF) perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif
endmodule

// File: doc/conv_window_scheduler.md
# conv_window_scheduler

Address and flag sequencer for the convolution datapath. It walks the input-row buffer and the filter buffer tap by tap: per window position, per filter, per tap. It produces the read addresses plus the `co_filter`, `end_of_filter` and `end_of_row` flags that the main controller turns into `clear_sum`, `store_buffer`, `next_filter` and `next_row`. It advances only when the datapath consumes a tap (`step`).

## Interface
Parameters:
- `ADDR_W`, 4: row-buffer address width; row length up to 2^ADDR_W.
- `NFILT_W`, 2: filter-count width; 1 to 2^NFILT_W−1 filters.
- `FADDR_W`, 6: filter-buffer address width.

Ports:
- `clk`  in  1  clock. One clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `ld_cfg`  in  1  load the `cfg_*` inputs; honoured only in IDLE or DONE.
- `cfg_rowlen`  in  ADDR_W+1  row length R.
- `cfg_fsize`  in  ADDR_W+1  filter size K.
- `cfg_stride`  in  ADDR_W  stride S.
- `cfg_nfilt`  in  NFILT_W  filter count F.
- `start`  in  1  begin one row pass; honoured only in IDLE or DONE with a valid config.
- `step`  in  1  datapath consumed the current tap.
- `data_addr`  out  ADDR_W  row-buffer read address, p+k.
- `filt_addr`  out  FADDR_W  filter-buffer read address, f·K+k.
- `co_filter`  out  1  current tap is the last tap of a filter.
- `end_of_filter`  out  1  current filter is the last filter.
- `end_of_row`  out  1  current window is the last window.
- `busy`  out  1  state is RUN.
- `done`  out  1  state is DONE.
- `cfg_err`  out  1  the loaded config is invalid.

## Operation
Counters:
- tap k in 0..K−1
- filter f in 0..F−1
- window base p, starting at 0 and incremented by S
- filter base fb = f·K, kept as an accumulator so no multiplier is used

Config rules:
- The config is invalid when K=0, S=0, F=0 or K>R.
- `cfg_err` is registered on `ld_cfg`.
- `start` is ignored while `cfg_err`=1.

States:
- **IDLE**: on `start` → RUN; k, f, p and fb are cleared.
- **RUN**: on `step` the counters advance as follows.
  - If k<K−1: k++.
  - Else k=0 and the filter advances:
    - if f<F−1: f++, fb+=K;
    - else f=0, fb=0, and the window advances: if p+S+K ≤ R then p+=S, otherwise → DONE.
- **DONE**: holds until `start` (→ RUN, counters cleared). `ld_cfg` is accepted in this state.

Flags are combinational from the registered counters and are forced to 0 outside RUN:
- `co_filter` = (k==K−1)
- `end_of_filter` = (f==F−1)
- `end_of_row` = (p+S+K > R)

Addresses:
- `data_addr` = p+k, always < R.
- `filt_addr` = fb+k.
- Both are held at 0 outside RUN.
- All comparisons are done at ADDR_W+2 bits so p+S+K cannot wrap.

Boundary conditions:
- `step` in IDLE or DONE: ignored.
- `start` or `ld_cfg` during RUN: ignored.
- `start` and `ld_cfg` in the same cycle in IDLE: the config is loaded and `start` is ignored that cycle.
- `rst` mid-pass: the next cycle is IDLE, all counters are 0, and all outputs are 0, including `cfg_err`. The config registers reset to 0, which makes the config invalid.

## Timing
- Reset values of all outputs are 0; the state resets to IDLE.
- `start` in cycle n gives `busy`=1 and `data_addr`=`filt_addr`=0 in cycle n+1.
- Each `step` in cycle n updates the addresses and flags in cycle n+1. There is no other latency.
- Throughput is one tap per cycle when `step` is held high.
- The final `step` (with all three flags = 1) gives `done`=1 and `busy`=0 in the next cycle.
- Total steps per pass = W·F·K, where W = ⌊(R−K)/S⌋+1.

## Configuration
- Macro `CONV_SCHED_PERF_EN`.
- When defined, two extra output ports are added:
  - `perf_steps`, 16 bits: counts accepted steps.
  - `perf_stalls`, 16 bits: counts RUN cycles with `step`=0.
- Both counters clear on `rst` and on accepted `start`, and saturate at 0xFFFF.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

## Test plan
- Full pass: R=8, K=3, S=2, F=2, `step` held high.
  - `data_addr` = 0,1,2,0,1,2,2,3,4,2,3,4,4,5,6,4,5,6.
  - `filt_addr` = 0..5 repeated 3 times.
  - `co_filter` is high at taps 2,5,8,…; `done` rises after exactly 18 steps.
- Last window exact fit: R=7, K=3, S=2, F=1 → windows p=0,2,4 (4+3=7), 9 steps; `end_of_row`=1 only at p=4.
- Stalls: same config as the full pass with `step` toggled every other cycle → the address sequence is unchanged and `done` arrives after 36 RUN cycles. With the macro defined, `perf_steps`=18 and `perf_stalls`=18.
- Invalid config: K=5, R=4 → `cfg_err`=1 and `start` is ignored. Repeat with S=0 → `cfg_err`=1.
- Reset mid-pass: `rst` asserted after step 7 → next cycle all outputs are 0. Reload config and `start` → the sequence restarts at address 0.
- Ignored inputs: `step` in IDLE, and `start`/`ld_cfg` with new values during RUN → no state change; the pass completes with the original config.
